// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dm_pkg;

  localparam int unsigned DM_DEPTH_WORDS = 1024;
  localparam int unsigned DM_XLEN        = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  typedef struct packed {
    logic               we;
    logic [DM_XLEN-1:0] addr;
    logic [DM_XLEN-1:0] wdata;
    logic [DM_XLEN-1:0] pc;
  } dm_req_t;

  // Word aligned and inside the memory.
  function automatic logic dm_addr_legal(input logic [DM_XLEN-1:0] addr,
                                         input int unsigned depth_words);
    return (addr[1:0] == 2'b00) && (addr < DM_XLEN'(depth_words * 4));
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select between the CPU port and the external port.
module dm_arb_pick
  import dm_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  input  logic wait_max,
  output logic any_c,
  output logic win_c
);

  always_comb begin
    any_c = req0 | req1;
    win_c = PORT_CPU;
    if (req1 && !req0) begin
      win_c = PORT_EXT;
    end else if (req0 && req1) begin
      if (PRIO_MODE == 0) begin
        win_c = ~rr_last;
      end else begin
        // Starvation relief: the external port is forced through once it has waited long enough.
        win_c = wait_max ? PORT_EXT : PORT_CPU;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory; one access per cycle,
// registered responses with an error flag for misaligned or out-of-range addresses.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int unsigned PRIO_MODE   = 0,
  parameter int unsigned MAX_WAIT    = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p0_pc,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [31:0] p1_pc,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  output logic        mem_RE,
  output logic [31:0] mem_PC,
  input  logic [31:0] mem_RD
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  dm_req_t             req0_s;
  dm_req_t             req1_s;
  dm_req_t             sel_s;
  logic                rr_last;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_max_c;
  logic                any_c;
  logic                win_c;
  logic                grant_c;
  logic                legal_c;
  logic [31:0]         resp_rdata_c;
  logic                resp_err_c;

  assign wait_max_c = (wait_cnt == WAIT_W'(MAX_WAIT));

  dm_arb_pick #(
    .PRIO_MODE(PRIO_MODE)
  ) u_pick (
    .req0    (p0_req),
    .req1    (p1_req),
    .rr_last (rr_last),
    .wait_max(wait_max_c),
    .any_c   (any_c),
    .win_c   (win_c)
  );

  // Grant, legality and memory drive for the selected port.
  always_comb begin
    req0_s       = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, pc: p0_pc};
    req1_s       = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, pc: p1_pc};
    sel_s        = (win_c == PORT_EXT) ? req1_s : req0_s;
    grant_c      = any_c && !Reset;
    legal_c      = dm_addr_legal(sel_s.addr, DEPTH_WORDS);
    p0_gnt       = grant_c && (win_c == PORT_CPU);
    p1_gnt       = grant_c && (win_c == PORT_EXT);
    mem_A        = '0;
    mem_WD       = '0;
    mem_PC       = '0;
    mem_WE       = 1'b0;
    mem_RE       = 1'b0;
    if (grant_c && legal_c) begin
      mem_A  = sel_s.addr;
      mem_WD = sel_s.wdata;
      mem_PC = sel_s.pc;
      mem_WE = sel_s.we;
      mem_RE = ~sel_s.we;
    end
    resp_rdata_c = (grant_c && legal_c && !sel_s.we) ? mem_RD : '0;
    resp_err_c   = grant_c && !legal_c;
  end

  // Response registers, round-robin history and external-port wait counter.
  always_ff @(posedge clk) begin
    if (Reset) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
      p1_err    <= 1'b0;
      rr_last   <= PORT_EXT;
      wait_cnt  <= '0;
    end else begin
      p0_rvalid <= p0_gnt;
      p0_rdata  <= p0_gnt ? resp_rdata_c : '0;
      p0_err    <= p0_gnt && resp_err_c;
      p1_rvalid <= p1_gnt;
      p1_rdata  <= p1_gnt ? resp_rdata_c : '0;
      p1_err    <= p1_gnt && resp_err_c;
      if (grant_c) begin
        rr_last <= win_c;
      end
      if (p1_req && !p1_gnt) begin
        if (!wait_max_c) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule
